// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;
  localparam int SA_MIN_WIDTH     = 2;
  localparam int SA_MAX_WIDTH     = 32;

  // Cycles from the accepting edge until done_valid is visible.
  function automatic int sa_latency(input int width);
    return width;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; master is the producer/consumer, slave is the adder.
interface serial_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, sum, cout, done_valid, busy
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, sum, cout, done_valid, busy
  );

endinterface

// File: rtl/halfadder.sv
// Single-bit half adder cell: sum and carry of two input bits.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_fa_slice.sv
// Combinational full-adder slice built from two half adders and an OR of their carries.
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  halfadder u_ha1 (
    .a (a),
    .b (b),
    .s (w_s1),
    .c (w_c1)
  );

  halfadder u_ha2 (
    .a (w_s1),
    .b (ci),
    .s (s),
    .c (w_c2)
  );

  // Both half-adder carries can never be high together, so OR equals the full-adder carry.
  assign co = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder slice processes operands LSB first, one bit per clock,
// behind a start handshake for operands and a done handshake for the result.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_slice_s;
  logic             w_slice_co;
  logic             w_accept;
  logic             w_last;
  logic             w_start_ready;
  logic             w_busy;
  logic             w_done_valid;

  serial_fa_slice u_slice (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_slice_s),
    .co (w_slice_co)
  );

  assign w_accept = (r_state == IDLE) && bus.start_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake outputs depend on registered state only, never on start_valid or done_ready.
  always_comb begin
    w_next_state  = r_state;
    w_start_ready = 1'b0;
    w_busy        = 1'b0;
    w_done_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_start_ready = 1'b1;
        if (bus.start_valid) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_done_valid = 1'b1;
        if (bus.done_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operands shift out LSB first while each new sum bit enters at the MSB of the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= bus.a;
      r_b_sr   <= bus.b;
      r_sum_sr <= '0;
      r_carry  <= bus.cin;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= {w_slice_s, r_sum_sr[WIDTH-1:1]};
      r_carry  <= w_slice_co;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_slice_co;
      end
    end
  end

  assign bus.start_ready = w_start_ready;
  assign bus.busy        = w_busy;
  assign bus.done_valid  = w_done_valid;
  assign bus.sum         = r_sum_sr;
  assign bus.cout        = r_cout;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that sits directly downstream of the `halfadder` cell. It chains two `halfadder` instances and a carry flip-flop into a full-adder slice, then processes one bit per clock, LSB first. A valid/ready handshake accepts two `WIDTH`-bit operands, and a second handshake returns the sum and carry-out. Intended for area-constrained datapaths where one full-adder slice replaces a `WIDTH`-bit parallel adder.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_valid` input 1: operands and `cin` are valid.
- `start_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: operand A; sampled on the accepting edge.
- `b` input WIDTH: operand B; sampled on the accepting edge.
- `cin` input 1: carry-in; sampled on the accepting edge.
- `sum` output WIDTH: result; stable while `done_valid` is high.
- `cout` output 1: carry-out of bit WIDTH-1.
- `done_valid` output 1: result is available.
- `done_ready` input 1: consumer accepts the result.
- `busy` output 1: high in RUN.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `start_ready`=1.
  - On `start_valid & start_ready`: load shift registers `a_sr`←`a` and `b_sr`←`b`, set carry flop←`cin`, bit counter←0, `sum_sr`←0, go to RUN.
- RUN, every cycle:
  - Slice inputs are `a_sr[0]`, `b_sr[0]` and the carry flop.
  - Sum bit = `a_sr[0]^b_sr[0]^carry`.
  - Carry = `(a_sr[0]&b_sr[0]) | ((a_sr[0]^b_sr[0])&carry)`, formed as HA1 carry OR HA2 carry.
  - `sum_sr` shifts right, with the new sum bit entering at the MSB.
  - `a_sr` and `b_sr` shift right; carry flop←slice carry; counter increments.
  - When counter == WIDTH-1 on this edge, go to DONE and load `cout`←slice carry.
- DONE:
  - `done_valid`=1; `sum`=`sum_sr` and `cout` are held.
  - On `done_ready`, go to IDLE and drop `done_valid` on the same edge.
- `start_valid` is ignored outside IDLE. No queuing; the upstream holds `start_valid`.
- Changes to `a`, `b` or `cin` after the accepting edge have no effect on the in-flight operation.
- Arithmetic is unsigned: `{cout,sum}` = `a + b + cin`, and results wrap modulo 2^WIDTH with the overflow bit on `cout`.
- Counter width is $clog2(WIDTH); no wrap occurs, since the FSM leaves RUN at WIDTH-1.

## Timing
- Reset values: state IDLE, `start_ready`=1, `done_valid`=0, `busy`=0, `sum`=0, `cout`=0, all shift registers and the counter 0, carry flop 0.
- Reset while in RUN or DONE aborts the operation: no `done_valid` pulse, and IDLE is entered on the next edge.
- Latency: with the operands accepted on edge E0, `done_valid` is high after edge E0+WIDTH.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH in RUN, at least 1 in DONE, and 1 in IDLE.
- If `done_ready` is already high when DONE is entered, `done_valid` is high for exactly one cycle.
- `start_ready`, `busy` and `done_valid` are decoded from registered state only; there is no combinational path from `start_valid` or `done_ready` to any output.

## Structure
- Package `adder_pkg` holds:
  - the state enum `sa_state_t` {IDLE, RUN, DONE};
  - the constant `SA_DEFAULT_WIDTH = 8`.
- The natural sub-module is `serial_fa_slice`: two `halfadder` instances plus an OR gate, purely combinational, with ports `a`, `b`, `ci`, `s`, `co`.
- The carry flop, shift registers, counter and FSM live in `serial_adder`.

## Test plan
- Reset, then WIDTH=8, a=0x5A, b=0x3C, cin=0:
  - sum=0x96, cout=0;
  - `done_valid` rises exactly 8 edges after acceptance;
  - `busy` is high for 8 cycles.
- a=0xFF, b=0x01, cin=0 gives sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 gives sum=0x00, cout=1.
- Backpressure: hold `done_ready`=0 for 5 cycles in DONE.
  - `done_valid`, sum and cout stay constant, and `start_ready`=0 throughout.
  - Release `done_ready`: `done_valid` falls on the next edge and `start_ready` rises.
- Toggle `start_valid` and change a/b during RUN: the result equals the sum of the originally captured operands, and no second operation starts.
- Assert `rst` at RUN cycle 4 with a=0x0F, b=0x01:
  - next cycle, outputs are at their reset values;
  - `done_valid` never pulses;
  - a following operation 0x01+0x01 gives 0x02.
- Random sweep with WIDTH=2 and WIDTH=16, at least 1000 operations with random `done_ready` stalls, scored against `a+b+cin`.
